// File: rtl/beta_pkg.sv
// Shared types and unit indices for the beta exe-stage multi-cycle sequencer.
package beta_pkg;

  typedef enum logic [1:0] {
    MCU_IDLE,
    MCU_ISSUE,
    MCU_WAIT,
    MCU_DONE
  } mcu_state_t;

  localparam int MCU_UNIT_SHU = 0;
  localparam int MCU_UNIT_LSU = 1;

endpackage

// File: rtl/beta_exe_mcu_timer.sv
// Saturating issue-to-completion cycle counter; expired_o flags count == TimeoutCycles.
// TimeoutCycles = 0 disables expiry entirely.
module beta_exe_mcu_timer #(
  parameter int TimeoutCycles = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
  localparam bit TimerOn = (TimeoutCycles != 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = TimerOn && (cnt_q == CntMax);

endmodule

// File: rtl/beta_exe_mcu_sequencer.sv
// Exe-stage sequencer for multi-cycle units: one op in flight, level enable held until the
// unit reports busy, exe-stage stall, single-cycle done pulse, sticky timeout and flush.
//   state     | meaning
//   MCU_IDLE  | no op in flight; issue when an unskipped request is present
//   MCU_ISSUE | enable held on the selected unit, waiting for its busy
//   MCU_WAIT  | unit working, waiting for busy to drop
//   MCU_DONE  | done pulse; decode advances this cycle
module beta_exe_mcu_sequencer
  import beta_pkg::*;
#(
  parameter int  NumUnits      = 2,
  parameter int  TimeoutCycles = 256,
  localparam int UnitIdxW      = ($clog2(NumUnits) > 1) ? $clog2(NumUnits) : 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                mcu_dec_stage_busy_i,
  input  logic [NumUnits-1:0] mcu_req_i,
  input  logic [NumUnits-1:0] mcu_skip_i,
  input  logic                mcu_flush_i,
  input  logic [NumUnits-1:0] mcu_unit_busy_i,
  output logic [NumUnits-1:0] mcu_unit_en_o,
  output logic [UnitIdxW-1:0] mcu_active_unit_o,
  output logic                mcu_exe_stage_busy_o,
  output logic                mcu_done_o,
  output logic                mcu_timeout_o
);

  function automatic logic [UnitIdxW-1:0] lowest_idx(input logic [NumUnits-1:0] vec);
    logic [UnitIdxW-1:0] idx;
    idx = '0;
    for (int i = NumUnits - 1; i >= 0; i--) begin
      if (vec[i]) idx = UnitIdxW'(i);
    end
    return idx;
  endfunction

  mcu_state_t          state_q, state_d;
  logic [UnitIdxW-1:0] idx_q, idx_d;
  logic [NumUnits-1:0] en_q, en_d;
  logic                timeout_q, timeout_d;

  logic [NumUnits-1:0] cand;
  logic [UnitIdxW-1:0] issue_idx;
  logic                need;
  logic                act_busy;
  logic                tmr_clr;
  logic                tmr_en;
  logic                tmr_expired;

  assign cand      = mcu_req_i & ~mcu_skip_i;
  assign need      = ~mcu_dec_stage_busy_i & ~mcu_flush_i & (|cand);
  assign issue_idx = lowest_idx(cand);
  assign act_busy  = mcu_unit_busy_i[idx_q];

  beta_exe_mcu_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= MCU_IDLE;
      idx_q     <= '0;
      en_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
    end
  end

  // Flush overrides every transition; timeout overrides the normal ack/complete path.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    timeout_d = timeout_q;
    tmr_clr   = 1'b0;
    if (mcu_flush_i) begin
      state_d = MCU_IDLE;
      en_d    = '0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        MCU_IDLE: begin
          if (need) begin
            state_d = MCU_ISSUE;
            idx_d   = issue_idx;
            en_d    = NumUnits'(1) << issue_idx;
            tmr_clr = 1'b1;
          end
        end
        MCU_ISSUE: begin
          if (tmr_expired) begin
            state_d   = MCU_DONE;
            en_d      = '0;
            timeout_d = 1'b1;
          end else if (act_busy) begin
            state_d = MCU_WAIT;
            en_d    = '0;
          end
        end
        MCU_WAIT: begin
          if (tmr_expired) begin
            state_d   = MCU_DONE;
            timeout_d = 1'b1;
          end else if (!act_busy) begin
            state_d = MCU_DONE;
          end
        end
        MCU_DONE: state_d = MCU_IDLE;
        default:  state_d = MCU_IDLE;
      endcase
    end
  end

  always_comb begin
    mcu_exe_stage_busy_o = 1'b0;
    mcu_done_o           = 1'b0;
    tmr_en               = 1'b0;
    unique case (state_q)
      MCU_IDLE: mcu_exe_stage_busy_o = need;
      MCU_ISSUE, MCU_WAIT: begin
        mcu_exe_stage_busy_o = ~mcu_flush_i;
        tmr_en               = 1'b1;
      end
      MCU_DONE: mcu_done_o = 1'b1;
      default:  mcu_done_o = 1'b0;
    endcase
  end

  assign mcu_unit_en_o     = en_q;
  assign mcu_active_unit_o = idx_q;
  assign mcu_timeout_o     = timeout_q;

endmodule

// File: tb/tb_beta_exe_mcu_sequencer.sv
// Directed and random checks of the multi-cycle sequencer against a cycle-level reference model.
module tb_beta_exe_mcu_sequencer;
  import beta_pkg::*;

  localparam int TO = 8;

  logic       clk;
  logic       rstn;
  logic       dec_busy;
  logic [1:0] req;
  logic [1:0] skip;
  logic       flush;
  logic [1:0] unit_busy;
  logic [1:0] en_o;
  logic [0:0] active_o;
  logic       exe_busy_o;
  logic       done_o;
  logic       timeout_o;

  beta_exe_mcu_sequencer #(
    .NumUnits     (2),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .mcu_dec_stage_busy_i(dec_busy),
    .mcu_req_i           (req),
    .mcu_skip_i          (skip),
    .mcu_flush_i         (flush),
    .mcu_unit_busy_i     (unit_busy),
    .mcu_unit_en_o       (en_o),
    .mcu_active_unit_o   (active_o),
    .mcu_exe_stage_busy_o(exe_busy_o),
    .mcu_done_o          (done_o),
    .mcu_timeout_o       (timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // reference model: an op is in flight, has been acknowledged, or is finishing this cycle
  bit         m_inflight, m_acked, m_fin, m_to;
  int         m_idx, m_elapsed;
  logic [1:0] m_en;

  // unit behaviour: busy rises in the first enabled cycle and lasts dur[u] cycles
  int dur[2];
  int unit_left[2];
  bit stuck[2];

  bit         last_exe_busy;
  int         n_en, n_stall, n_done;
  logic [1:0] first_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_acked = 0; m_fin = 0; m_to = 0;
    m_idx = 0; m_elapsed = 0; m_en = 2'b00;
  endtask

  task automatic clr_stats();
    n_en = 0; n_stall = 0; n_done = 0; first_en = 2'b00;
  endtask

  task automatic cycle();
    logic [1:0] cand;
    bit         need, exp_busy;
    int         lo;
    for (int u = 0; u < 2; u++) begin
      if (unit_left[u] == 0 && m_en[u]) unit_left[u] = dur[u];
      unit_busy[u] = stuck[u] || (unit_left[u] > 0);
    end
    @(negedge clk);
    cand = req & ~skip;
    need = !dec_busy && !flush && (cand != 2'b00);
    lo = cand[0] ? 0 : 1;
    exp_busy = !flush && (m_inflight || (!m_fin && need));
    chk("unit_en", 32'(en_o), 32'(m_en));
    chk("exe_busy", 32'(exe_busy_o), 32'(exp_busy));
    chk("done", 32'(done_o), 32'(m_fin));
    chk("timeout", 32'(timeout_o), 32'(m_to));
    if (m_inflight || m_fin) chk("active_unit", 32'(active_o), 32'(m_idx));
    last_exe_busy = exe_busy_o;
    if (en_o != 2'b00) begin
      if (n_en == 0) first_en = en_o;
      n_en++;
    end
    if (exe_busy_o) n_stall++;
    if (done_o) n_done++;
    if (flush) begin
      m_inflight = 0; m_fin = 0; m_en = 2'b00; m_elapsed = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_inflight) begin
      if (m_elapsed == TO) begin
        m_fin = 1; m_inflight = 0; m_en = 2'b00; m_to = 1;
      end else if (!m_acked && unit_busy[m_idx]) begin
        m_acked = 1; m_en = 2'b00;
      end else if (m_acked && !unit_busy[m_idx]) begin
        m_fin = 1; m_inflight = 0;
      end
      if (m_elapsed < TO) m_elapsed++;
    end else if (need) begin
      m_inflight = 1; m_acked = 0; m_idx = lo; m_elapsed = 0;
      m_en = 2'b00;
      m_en[lo] = 1'b1;
    end
    for (int u = 0; u < 2; u++) if (unit_left[u] > 0) unit_left[u]--;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = 2'b00; skip = 2'b00; flush = 1'b0; dec_busy = 1'b0; unit_busy = 2'b00;
    for (int u = 0; u < 2; u++) begin
      unit_left[u] = 0; stuck[u] = 0; dur[u] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    last_exe_busy = 0;
    @(negedge clk);
    chk("rst_unit_en", 32'(en_o), 32'h0);
    chk("rst_active", 32'(active_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    chk("rst_exe_busy", 32'(exe_busy_o), 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [1:0] r, input logic [1:0] s);
    bit retired;
    retired = 0;
    req = r; skip = s;
    for (int i = 0; i < 40 && !retired; i++) begin
      cycle();
      if (!last_exe_busy) retired = 1;
    end
    req = 2'b00; skip = 2'b00;
    checks++;
    assert (retired) else begin
      errors++;
      $error("FAIL retire_bound: observed=still stalled expected=retired within 40 cycles");
    end
  endtask

  initial begin
    logic [1:0] shu, lsu;
    int r;
    shu = 2'b00; shu[MCU_UNIT_SHU] = 1'b1;
    lsu = 2'b00; lsu[MCU_UNIT_LSU] = 1'b1;
    clr_stats();
    do_reset();

    // single SHU op, unit busy for 4 cycles
    clr_stats();
    dur[0] = 4;
    run_instr(shu, 2'b00);
    chk("t1_en_cycles", 32'(n_en), 32'd1);
    chk("t1_stall_cycles", 32'(n_stall), 32'd6);
    chk("t1_done_pulses", 32'(n_done), 32'd1);

    // skipped and empty requests pass straight through
    clr_stats();
    run_instr(shu, shu);
    run_instr(2'b00, 2'b00);
    repeat (2) cycle();
    chk("t2_en_cycles", 32'(n_en), 32'd0);
    chk("t2_stall_cycles", 32'(n_stall), 32'd0);
    chk("t2_done_pulses", 32'(n_done), 32'd0);

    // two requests: lowest unit wins
    clr_stats();
    dur[0] = 2; dur[1] = 2;
    run_instr(2'b11, 2'b00);
    chk("t3_first_en", 32'(first_en), 32'(shu));
    chk("t3_done_pulses", 32'(n_done), 32'd1);

    // back-to-back LSU then SHU
    clr_stats();
    dur[0] = 3; dur[1] = 3;
    run_instr(lsu, 2'b00);
    run_instr(shu, 2'b00);
    chk("t6_en_cycles", 32'(n_en), 32'd2);
    chk("t6_done_pulses", 32'(n_done), 32'd2);

    // flush while waiting, then a clean new issue
    clr_stats();
    dur[0] = 6; dur[1] = 2;
    req = shu;
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; req = 2'b00;
    cycle();
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_en_after_flush", 32'(en_o), 32'h0);
    clr_stats();
    run_instr(lsu, 2'b00);
    chk("t5_reissue_done", 32'(n_done), 32'd1);

    // timeout on a stuck LSU, sticky until reset
    do_reset();
    clr_stats();
    stuck[1] = 1;
    run_instr(lsu, 2'b00);
    chk("t4_stall_cycles", 32'(n_stall), 32'd10);
    chk("t4_done_pulses", 32'(n_done), 32'd1);
    stuck[1] = 0;
    repeat (5) cycle();
    chk("t4_timeout_sticky", 32'(timeout_o), 32'h1);
    do_reset();

    // reset in the middle of an op
    dur[1] = 5;
    req = lsu;
    repeat (3) cycle();
    do_reset();

    // random instruction stream
    for (int c = 0; c < 400; c++) begin
      if (!last_exe_busy) begin
        r = $urandom_range(0, 7);
        req = (r < 3) ? shu : (r < 6) ? lsu : (r == 6) ? 2'b11 : 2'b00;
        skip = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      end
      dec_busy = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 24) == 0);
      dur[0] = $urandom_range(0, 10);
      dur[1] = $urandom_range(0, 10);
      cycle();
    end
    flush = 1'b0; dec_busy = 1'b0; req = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
